escalonador_round_robin: RTL and testbench

- Parametrised successor to the single-quantum context-switch logic in the CPU: a round-robin scheduler for up to NUM_PROC user processes, each in a fixed memory partition.
- Sits beside the CPU core. Counts retired instructions per quantum and detects IO and end-of-process events.
- Selects the next active process, keeps a saved PC per process, and requests a context switch through a req/ack handshake with the BIOS save routine.

---
 rtl/escalonador_round_robin.sv | 212 +++++++++++++++++++++
 tb/tb_escalonador_round_robin.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/escalonador_round_robin.sv
// Round-robin process scheduler that sits beside the CPU core.
// It counts retired instructions per time slice and watches for IO and
// end-of-process instructions. It picks the next process to run, keeps a
// saved return PC for each slot, and asks the BIOS save/restore routine
// for a context switch through a switch_req / switch_ack handshake.
module escalonador_round_robin #(
  parameter int NUM_PROC  = 10,
  parameter int QUANTUM   = 16,
  parameter int PC_WIDTH  = 32,
  parameter int PART_SIZE = 300
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                retire,
  input  logic                instr_io,
  input  logic                instr_fim,
  input  logic                create_valid,
  input  logic [3:0]          create_id,
  input  logic                switch_ack,
  output logic                switch_req,
  output logic [1:0]          switch_motivo,
  output logic [PC_WIDTH-1:0] pc_retorno,
  output logic [3:0]          processo_atual,
  output logic [3:0]          processo_prox,
  output logic [NUM_PROC-1:0] ativos,
  output logic                ocioso
);

  localparam int CNT_W = $clog2(QUANTUM);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM - 1);

  localparam logic [1:0] MOT_QUANTUM = 2'b00;
  localparam logic [1:0] MOT_IO      = 2'b01;
  localparam logic [1:0] MOT_FIM     = 2'b10;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    EXEC   = 2'd1,
    TROCA  = 2'd2
  } estado_t;

  estado_t               estado_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [3:0]            atual_q;
  logic [3:0]            prox_q;
  logic [NUM_PROC-1:0]   ativos_q;
  logic [NUM_PROC-1:0]   ativos_d;
  logic                  req_q;
  logic [1:0]            motivo_q;
  logic [PC_WIDTH-1:0]   pcret_q;
  logic [PC_WIDTH-1:0]   salvo_q [1:NUM_PROC];

  logic [NUM_PROC-1:0]   cria_vec;
  logic [NUM_PROC-1:0]   atual_mask;
  logic [NUM_PROC-1:0]   mask_sel;
  logic                  outros;
  logic                  ev_fim;
  logic                  ev_io;
  logic [3:0]            sel;
  logic [PC_WIDTH-1:0]   salvo_sel;
  logic [PC_WIDTH-1:0]   pc_inc;

  // Start address of partition k, truncated to the PC width.
  function automatic logic [PC_WIDTH-1:0] base_part(input int k);
    return PC_WIDTH'(k * PART_SIZE);
  endfunction

  // First active id strictly above 'atual' (wrapping to 1). The current id
  // itself is only reachable after every other id, as the last candidate.
  function automatic logic [3:0] proximo(input logic [3:0]          atual,
                                         input logic [NUM_PROC-1:0] mask);
    logic [3:0] acima;
    logic [3:0] abaixo;
    acima  = 4'd0;
    abaixo = 4'd0;
    for (int k = NUM_PROC; k >= 1; k--) begin
      if (mask[k-1]) begin
        if (k > int'(atual)) acima = 4'(k);
        else                 abaixo = 4'(k);
      end
    end
    return (acima != 4'd0) ? acima : abaixo;
  endfunction

  // Decode slot creation, the running-slot mask and the next active mask.
  always_comb begin
    cria_vec   = '0;
    atual_mask = '0;
    for (int k = 1; k <= NUM_PROC; k++) begin
      cria_vec[k-1]   = create_valid && (create_id == 4'(k)) && !ativos_q[k-1];
      atual_mask[k-1] = (atual_q == 4'(k));
    end
    ev_fim   = (estado_q == EXEC) && retire && instr_fim;
    ev_io    = (estado_q == EXEC) && retire && !instr_fim && instr_io;
    outros   = |(ativos_q & ~atual_mask);
    ativos_d = (ativos_q | cria_vec) & ~(ev_fim ? atual_mask : '0);
  end

  // Next-process selection and the return PC that goes with it.
  always_comb begin
    pc_inc    = pc + PC_WIDTH'(1);
    mask_sel  = ev_fim ? (ativos_q & ~atual_mask) : ativos_q;
    sel       = proximo(atual_q, mask_sel);
    salvo_sel = '0;
    for (int k = 1; k <= NUM_PROC; k++) begin
      if (sel == 4'(k)) salvo_sel = salvo_q[k];
    end
    // An IO switch with no other process re-selects the current one, whose
    // PC is being saved on this very edge, so forward the new value.
    if (ev_io && (sel == atual_q)) salvo_sel = pc_inc;
  end

  // Scheduler FSM, slot table, saved PCs and registered handshake outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
      atual_q  <= 4'd0;
      prox_q   <= 4'd0;
      ativos_q <= '0;
      req_q    <= 1'b0;
      motivo_q <= MOT_QUANTUM;
      pcret_q  <= '0;
      for (int k = 1; k <= NUM_PROC; k++) salvo_q[k] <= base_part(k);
    end else begin
      ativos_q <= ativos_d;
      // A newly activated slot restarts at the beginning of its partition.
      for (int k = 1; k <= NUM_PROC; k++) begin
        if (cria_vec[k-1]) salvo_q[k] <= base_part(k);
      end

      case (estado_q)
        OCIOSO: begin
          if (ativos_q != '0) begin
            estado_q <= TROCA;
            req_q    <= 1'b1;
            motivo_q <= MOT_QUANTUM;
            prox_q   <= sel;
            pcret_q  <= salvo_sel;
          end
        end

        EXEC: begin
          if (retire) begin
            if (instr_fim) begin
              motivo_q <= MOT_FIM;
              if (outros) begin
                estado_q <= TROCA;
                req_q    <= 1'b1;
                prox_q   <= sel;
                pcret_q  <= salvo_sel;
              end else begin
                estado_q <= OCIOSO;
                atual_q  <= 4'd0;
              end
            end else if (instr_io) begin
              for (int k = 1; k <= NUM_PROC; k++) begin
                if (atual_q == 4'(k)) salvo_q[k] <= pc_inc;
              end
              motivo_q <= MOT_IO;
              estado_q <= TROCA;
              req_q    <= 1'b1;
              prox_q   <= sel;
              pcret_q  <= salvo_sel;
            end else if (cnt_q == CNT_MAX) begin
              for (int k = 1; k <= NUM_PROC; k++) begin
                if (atual_q == 4'(k)) salvo_q[k] <= pc_inc;
              end
              motivo_q <= MOT_QUANTUM;
              if (outros) begin
                estado_q <= TROCA;
                req_q    <= 1'b1;
                prox_q   <= sel;
                pcret_q  <= salvo_sel;
              end else begin
                // Sole runnable process: start a fresh slice in place.
                cnt_q <= '0;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        TROCA: begin
          // Everything about the pending switch holds until the BIOS acks.
          if (switch_ack) begin
            atual_q  <= prox_q;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            estado_q <= EXEC;
          end
        end

        default: begin
          estado_q <= OCIOSO;
          req_q    <= 1'b0;
        end
      endcase
    end
  end

  assign switch_req     = req_q;
  assign switch_motivo  = motivo_q;
  assign pc_retorno     = pcret_q;
  assign processo_atual = atual_q;
  assign processo_prox  = prox_q;
  assign ativos         = ativos_q;
  assign ocioso         = (ativos_q == '0);

endmodule

// File: tb/tb_escalonador_round_robin.sv
// Self-checking bench for the round-robin scheduler: a table of retire
// scenarios plus hand-written multi-cycle sequences, with expected switch
// requests queued when the triggering stimulus is driven.
module tb_escalonador_round_robin;

  localparam int NP = 10;
  localparam int PW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] pc = '0;
  logic          retire = 1'b0;
  logic          instr_io = 1'b0;
  logic          instr_fim = 1'b0;
  logic          create_valid = 1'b0;
  logic [3:0]    create_id = 4'd0;
  logic          switch_ack = 1'b0;
  logic          switch_req;
  logic [1:0]    switch_motivo;
  logic [PW-1:0] pc_retorno;
  logic [3:0]    processo_atual;
  logic [3:0]    processo_prox;
  logic [NP-1:0] ativos;
  logic          ocioso;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  prox;
    logic [1:0]  mot;
    logic [31:0] pcret;
  } sw_t;

  sw_t sb[$];

  typedef struct {
    int          cria;
    int          n_plain;
    logic [31:0] pc;
    logic        io;
    logic        fim;
    logic        sw;
    logic [3:0]  prox;
    logic [1:0]  mot;
    logic [31:0] pcret;
    logic [3:0]  atual;
    logic [9:0]  ativos;
  } vec_t;

  vec_t tab[9];

  escalonador_round_robin #(
    .NUM_PROC(NP), .QUANTUM(16), .PC_WIDTH(PW), .PART_SIZE(300)
  ) dut (
    .clock(clock), .reset(reset), .pc(pc), .retire(retire),
    .instr_io(instr_io), .instr_fim(instr_fim),
    .create_valid(create_valid), .create_id(create_id),
    .switch_ack(switch_ack), .switch_req(switch_req),
    .switch_motivo(switch_motivo), .pc_retorno(pc_retorno),
    .processo_atual(processo_atual), .processo_prox(processo_prox),
    .ativos(ativos), .ocioso(ocioso)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nome, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    retire       = 1'b0;
    instr_io     = 1'b0;
    instr_fim    = 1'b0;
    create_valid = 1'b0;
    create_id    = 4'd0;
  endtask

  task automatic chk_reset(input string nome);
    chk({nome, " switch_req"}, 32'(switch_req), 32'd0);
    chk({nome, " motivo"}, 32'(switch_motivo), 32'd0);
    chk({nome, " pc_retorno"}, pc_retorno, 32'd0);
    chk({nome, " atual"}, 32'(processo_atual), 32'd0);
    chk({nome, " prox"}, 32'(processo_prox), 32'd0);
    chk({nome, " ativos"}, 32'(ativos), 32'd0);
    chk({nome, " ocioso"}, 32'(ocioso), 32'd1);
  endtask

  // The triggering stimulus is already driven; count edges until switch_req.
  task automatic wait_req(input int lat, input string nome);
    int  n;
    sw_t e;
    n = 0;
    do begin
      cyc();
      n++;
      if (n == 1) clr_in();
    end while (!switch_req && n < 8);
    if (!switch_req) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: switch_req=0 after %0d cycles, expected 1", nome, n);
      if (sb.size() > 0) e = sb.pop_front();
    end else begin
      chk({nome, " latency"}, 32'(n), 32'(lat));
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: switch_req with empty scoreboard, expected none", nome);
      end else begin
        e = sb.pop_front();
        chk({nome, " prox"}, 32'(processo_prox), 32'(e.prox));
        chk({nome, " motivo"}, 32'(switch_motivo), 32'(e.mot));
        chk({nome, " pc_retorno"}, pc_retorno, e.pcret);
      end
    end
  endtask

  task automatic ack(input logic [3:0] exp_atual, input string nome);
    switch_ack = 1'b1;
    cyc();
    switch_ack = 1'b0;
    chk({nome, " req after ack"}, 32'(switch_req), 32'd0);
    chk({nome, " atual after ack"}, 32'(processo_atual), 32'(exp_atual));
  endtask

  task automatic plain(input int n, output bit saw);
    saw = 1'b0;
    for (int i = 0; i < n; i++) begin
      retire    = 1'b1;
      instr_io  = 1'b0;
      instr_fim = 1'b0;
      pc        = 32'(5000 + i);
      cyc();
      if (switch_req) saw = 1'b1;
    end
  endtask

  task automatic criar(input int id);
    create_valid = 1'b1;
    create_id    = 4'(id);
    cyc();
    clr_in();
  endtask

  task automatic push(input logic [3:0] p, input logic [1:0] m, input logic [31:0] r);
    sw_t e;
    e.prox  = p;
    e.mot   = m;
    e.pcret = r;
    sb.push_back(e);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    string nm;

    //          cria n   pc    io fim sw prox mot    pcret  atual ativos
    tab[0] = '{0, 7,  32'd305, 1'b0, 1'b0, 1'b1, 4'd2, 2'b00, 32'd600, 4'd2, 10'h003};
    tab[1] = '{0, 15, 32'd610, 1'b0, 1'b0, 1'b1, 4'd1, 2'b00, 32'd306, 4'd1, 10'h003};
    tab[2] = '{0, 15, 32'd320, 1'b0, 1'b0, 1'b1, 4'd2, 2'b00, 32'd611, 4'd2, 10'h003};
    tab[3] = '{0, 0,  32'd620, 1'b1, 1'b0, 1'b1, 4'd1, 2'b01, 32'd321, 4'd1, 10'h003};
    tab[4] = '{0, 15, 32'd330, 1'b0, 1'b0, 1'b1, 4'd2, 2'b00, 32'd621, 4'd2, 10'h003};
    tab[5] = '{0, 0,  32'd640, 1'b0, 1'b1, 1'b1, 4'd1, 2'b10, 32'd331, 4'd1, 10'h001};
    tab[6] = '{3, 15, 32'd340, 1'b0, 1'b0, 1'b1, 4'd3, 2'b00, 32'd900, 4'd3, 10'h005};
    tab[7] = '{0, 0,  32'd950, 1'b0, 1'b1, 1'b1, 4'd1, 2'b10, 32'd341, 4'd1, 10'h001};
    tab[8] = '{0, 0,  32'd360, 1'b0, 1'b1, 1'b0, 4'd0, 2'b10, 32'd0,   4'd0, 10'h000};

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    chk_reset("reset");
    reset = 1'b1;
    cyc();

    // First process from idle: request two cycles after the create
    create_valid = 1'b1;
    create_id    = 4'd1;
    push(4'd1, 2'b00, 32'd300);
    wait_req(2, "create1");
    chk("create1 atual during req", 32'(processo_atual), 32'd0);
    ack(4'd1, "create1");

    // Sole process: 40 retires never request a switch
    plain(40, saw);
    chk("alone 40 retires no req", 32'(saw), 32'd0);
    clr_in();
    criar(2);
    chk("create2 ativos", 32'(ativos), 32'h003);

    // Table: after 40 retires the counter sits at 8, so 8 more expire it
    for (int i = 0; i < 9; i++) begin
      nm = $sformatf("vec%0d", i);
      if (tab[i].cria != 0) criar(tab[i].cria);
      plain(tab[i].n_plain, saw);
      chk({nm, " no early req"}, 32'(saw), 32'd0);
      retire    = 1'b1;
      pc        = tab[i].pc;
      instr_io  = tab[i].io;
      instr_fim = tab[i].fim;
      if (tab[i].sw) begin
        push(tab[i].prox, tab[i].mot, tab[i].pcret);
        wait_req(1, nm);
        chk({nm, " ativos"}, 32'(ativos), 32'(tab[i].ativos));
        ack(tab[i].atual, nm);
      end else begin
        cyc();
        clr_in();
        cyc();
        chk({nm, " no req"}, 32'(switch_req), 32'd0);
        chk({nm, " atual"}, 32'(processo_atual), 32'(tab[i].atual));
        chk({nm, " ativos"}, 32'(ativos), 32'(tab[i].ativos));
        chk({nm, " ocioso"}, 32'(ocioso), 32'(tab[i].ativos == 10'h000));
        chk({nm, " motivo"}, 32'(switch_motivo), 32'(tab[i].mot));
      end
    end

    // Out-of-range creates are ignored
    criar(0);
    criar(11);
    cyc();
    chk("bad id ativos", 32'(ativos), 32'd0);
    chk("bad id req", 32'(switch_req), 32'd0);

    // IO with no other process re-selects itself with pc+1
    create_valid = 1'b1;
    create_id    = 4'd4;
    push(4'd4, 2'b00, 32'd1200);
    wait_req(2, "create4");
    ack(4'd4, "create4");
    retire   = 1'b1;
    instr_io = 1'b1;
    pc       = 32'd1250;
    push(4'd4, 2'b01, 32'd1251);
    wait_req(1, "io alone");
    ack(4'd4, "io alone");

    // Creating an already-active slot must not reset its saved PC
    criar(5);
    plain(15, saw);
    chk("p4 quantum no early req", 32'(saw), 32'd0);
    pc = 32'd1260;
    push(4'd5, 2'b00, 32'd1500);
    wait_req(1, "p4 quantum");
    ack(4'd5, "p4 quantum");
    criar(4);
    retire    = 1'b1;
    instr_fim = 1'b1;
    pc        = 32'd1600;
    push(4'd4, 2'b10, 32'd1261);
    wait_req(1, "fim5 after dup create");
    ack(4'd4, "fim5 after dup create");

    // Same-cycle create of the current id and fim: the slot ends inactive
    retire       = 1'b1;
    instr_fim    = 1'b1;
    create_valid = 1'b1;
    create_id    = 4'd4;
    cyc();
    clr_in();
    chk("fim+create ativos", 32'(ativos), 32'd0);
    chk("fim+create ocioso", 32'(ocioso), 32'd1);
    chk("fim+create atual", 32'(processo_atual), 32'd0);

    // Request held without ack while retire and event inputs toggle
    create_valid = 1'b1;
    create_id    = 4'd6;
    push(4'd6, 2'b00, 32'd1800);
    wait_req(2, "create6");
    for (int i = 0; i < 5; i++) begin
      retire    = i[0];
      instr_io  = i[1];
      instr_fim = ~i[0];
      pc        = 32'(7000 + i);
      cyc();
      nm = $sformatf("hold%0d", i);
      chk({nm, " req"}, 32'(switch_req), 32'd1);
      chk({nm, " prox"}, 32'(processo_prox), 32'd6);
      chk({nm, " pc_retorno"}, pc_retorno, 32'd1800);
      chk({nm, " motivo"}, 32'(switch_motivo), 32'd0);
      chk({nm, " ativos"}, 32'(ativos), 32'h020);
    end
    clr_in();

    // Asynchronous reset mid-wait returns everything at once
    reset = 1'b0;
    #1;
    chk_reset("mid reset");
    cyc();
    reset = 1'b1;
    cyc();
    chk("post reset req", 32'(switch_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
